// File: rtl/rmii_tx_pkg.sv
// Shared types and constants for the RMII transmit serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rmii_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        FCS,
        DROP,
        IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;  // 0x04C11DB7 bit-reversed
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    // Dibit k of a byte, LSB dibit first on the wire.
    function automatic logic [1:0] byte_dibit(input logic [7:0] b, input logic [1:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

    // Reflected CRC32 advanced by one dibit, bit 0 of the dibit first.
    function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_tx_serializer_if.sv
// Byte-wide AXI-stream link feeding the RMII transmit serializer.
// Latency: n/a (wiring only).
// Backpressure: tready from the slave, asserted only on dibit strobes where a byte is due.
// Signals: tdata[7:0] byte, tvalid, tready, tlast (end of frame), tuser (byte error mark).
interface rmii_tx_serializer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rmii_crc32_dibit.sv
// Ethernet CRC32 (reflected) accumulator advancing two bits per enabled cycle.
// Latency: o_crc reflects a dibit one clk after it is presented with i_en.
// Backpressure: none; i_en gates every update.
// Ports: clk, rst_n, i_init (restart from CRC_INIT), i_en (absorb i_dibit), i_dibit[1:0], o_crc[31:0].
module rmii_crc32_dibit
    import rmii_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // i_init together with i_en seeds and absorbs the first dibit in one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc32_dibit_step(i_init ? CRC_INIT : r_crc, i_dibit);
        end else if (i_init) begin
            r_crc <= CRC_INIT;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/rmii_tx_serializer.sv
// RMII TX serializer: AXI-stream bytes -> preamble/SFD + data dibits (+FCS) + inter-frame gap.
// Latency: first preamble dibit appears on the strobe after tvalid is seen in IDLE; pins are registered.
// Backpressure: tready only on a strobe where the next byte is due; a missing byte aborts the frame.
// Ports: clk, rst_n, rmii_clk_en (dibit strobe), s_axis (slave stream), rmii_d/rmii_en/rmii_er (PHY pins),
//        busy (not IDLE), underrun (one-clk pulse). Macro RMII_TX_FCS_EN appends a generated FCS.
module rmii_tx_serializer
    import rmii_tx_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int PRE_BYTES = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rmii_clk_en,
    rmii_tx_serializer_if.slave         s_axis,
    output logic [1:0]                  rmii_d,
    output logic                        rmii_en,
    output logic                        rmii_er,
    output logic                        busy,
    output logic                        underrun
);

    localparam logic [7:0] PRE_LAST = 8'(4 * (PRE_BYTES + 1) - 1);
    localparam logic [7:0] IFG_LAST = 8'(4 * IFG_BYTES - 1);

    // r_state/r_cnt describe the dibit currently on the pins.
    tx_state_t   r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_byte;
    logic        r_last;
    logic        r_user;
    logic [1:0]  r_d;
    logic        r_en;
    logic        r_er;
    logic        r_underrun;

    logic        w_pre_end;
    logic        w_byte_end;
    logic        w_take;

    function automatic logic [1:0] pre_dibit(input logic [7:0] idx);
        logic [7:0] b;
        b = (idx[7:2] == 6'(PRE_BYTES)) ? SFD_BYTE : PREAMBLE_BYTE;
        return byte_dibit(b, idx[1:0]);
    endfunction

    assign w_pre_end  = (r_state == PRE)  && (r_cnt == PRE_LAST);
    assign w_byte_end = (r_state == DATA) && (r_cnt == 8'd3);

    assign s_axis.tready = rmii_clk_en &&
                           (w_pre_end || (w_byte_end && !r_last) || (r_state == DROP));

    // A byte entering DATA (not one being discarded in DROP).
    assign w_take = s_axis.tready && s_axis.tvalid && (r_state != DROP);

`ifdef RMII_TX_FCS_EN
    logic [31:0] w_crc;
    logic        w_crc_en;
    logic [1:0]  w_crc_dibit;
    logic [3:0]  w_fcs_next;

    // The CRC absorbs each data dibit on the edge that puts it on the pins,
    // so it is final by the time the last data dibit is showing.
    assign w_crc_en    = w_take || (rmii_clk_en && (r_state == DATA) && (r_cnt != 8'd3));
    assign w_crc_dibit = w_take ? s_axis.tdata[1:0] : byte_dibit(r_byte, r_cnt[1:0] + 2'd1);
    assign w_fcs_next  = r_cnt[3:0] + 4'd1;

    rmii_crc32_dibit u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_init  (w_pre_end && w_take),
        .i_en    (w_crc_en),
        .i_dibit (w_crc_dibit),
        .o_crc   (w_crc)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_byte     <= '0;
            r_last     <= 1'b0;
            r_user     <= 1'b0;
            r_d        <= 2'b00;
            r_en       <= 1'b0;
            r_er       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (rmii_clk_en) begin
                case (r_state)
                    IDLE: begin
                        r_en <= 1'b0;
                        r_er <= 1'b0;
                        r_d  <= 2'b00;
                        if (s_axis.tvalid) begin
                            r_state <= PRE;
                            r_cnt   <= '0;
                            r_en    <= 1'b1;
                            r_d     <= pre_dibit(8'd0);
                        end
                    end
                    PRE, DATA: begin
                        if ((r_state == PRE) ? (r_cnt != PRE_LAST) : (r_cnt != 8'd3)) begin
                            r_cnt <= r_cnt + 8'd1;
                            r_d   <= (r_state == PRE) ? pre_dibit(r_cnt + 8'd1)
                                                      : byte_dibit(r_byte, r_cnt[1:0] + 2'd1);
                        end else if ((r_state == DATA) && r_last) begin
                            r_cnt <= '0;
                            r_er  <= 1'b0;
`ifdef RMII_TX_FCS_EN
                            r_state <= FCS;
                            r_d     <= ~w_crc[1:0];
`else
                            r_state <= IFG;
                            r_en    <= 1'b0;
                            r_d     <= 2'b00;
`endif
                        end else if (s_axis.tvalid) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_byte  <= s_axis.tdata;
                            r_last  <= s_axis.tlast;
                            r_user  <= s_axis.tuser;
                            r_d     <= s_axis.tdata[1:0];
                            r_er    <= s_axis.tuser;
                        end else begin
                            // Byte missing: one error dibit while still enabled, then discard.
                            r_state    <= DROP;
                            r_cnt      <= '0;
                            r_d        <= 2'b00;
                            r_er       <= 1'b1;
                            r_underrun <= 1'b1;
                        end
                    end
`ifdef RMII_TX_FCS_EN
                    FCS: begin
                        if (r_cnt != 8'd15) begin
                            r_cnt <= r_cnt + 8'd1;
                            r_d   <= ~w_crc[{w_fcs_next, 1'b0} +: 2];
                        end else begin
                            r_state <= IFG;
                            r_cnt   <= '0;
                            r_en    <= 1'b0;
                            r_d     <= 2'b00;
                        end
                    end
`endif
                    DROP: begin
                        r_en <= 1'b0;
                        r_er <= 1'b0;
                        r_d  <= 2'b00;
                        if (s_axis.tvalid && s_axis.tlast) begin
                            r_state <= IFG;
                            r_cnt   <= '0;
                        end
                    end
                    IFG: begin
                        r_en <= 1'b0;
                        r_er <= 1'b0;
                        r_d  <= 2'b00;
                        if (r_cnt != IFG_LAST) begin
                            r_cnt <= r_cnt + 8'd1;
                        end else if (s_axis.tvalid) begin
                            // Going straight to PRE keeps the gap at exactly the IFG length
                            // when the next frame is already waiting.
                            r_state <= PRE;
                            r_cnt   <= '0;
                            r_en    <= 1'b1;
                            r_d     <= pre_dibit(8'd0);
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                        r_er    <= 1'b0;
                        r_d     <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign rmii_d   = r_d;
    assign rmii_en  = r_en;
    assign rmii_er  = r_er;
    assign busy     = (r_state != IDLE);
    assign underrun = r_underrun;

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Testbench for rmii_tx_serializer: random and directed frames against a dibit-list reference model.
// Latency: n/a.
// Backpressure: the source presents bytes whenever it has them, except during a forced stall.
module tb_rmii_tx_serializer;

    localparam int IFG_BYTES = 12;
    localparam int PRE_BYTES = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rmii_clk_en = 1'b0;
    logic [1:0] rmii_d;
    logic       rmii_en;
    logic       rmii_er;
    logic       busy;
    logic       underrun;

    rmii_tx_serializer_if s_axis ();

    rmii_tx_serializer #(
        .IFG_BYTES (IFG_BYTES),
        .PRE_BYTES (PRE_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rmii_clk_en (rmii_clk_en),
        .s_axis      (s_axis),
        .rmii_d      (rmii_d),
        .rmii_en     (rmii_en),
        .rmii_er     (rmii_er),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t      src_q[$];
    logic [3:0] cap_q[$];   // {en, er, d} per strobe
    logic [3:0] exp_q[$];
    logic [7:0] f_dat[$];
    logic       f_usr[$];

    int         n_cmp = 0;
    int         n_err = 0;
    bit         slow = 1'b0;
    int         phase = 0;
    int         stall_at = -1;
    int         n_acc = 0;
    int         n_underrun = 0;
    int         n_hold_viol = 0;
    int         cap_start = 0;
    logic [3:0] prev_pins = 4'b0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

`ifdef RMII_TX_FCS_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction
`endif

    // One clk: drive inputs, note strobe/handshake at negedge, sample pins 1 after posedge.
    task automatic run_cycle();
        bit strobe;
        bit hs;
        if (src_q.size() > 0 && !(stall_at >= 0 && n_acc == stall_at)) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = src_q[0].data;
            s_axis.tlast  = src_q[0].last;
            s_axis.tuser  = src_q[0].user;
        end else begin
            s_axis.tvalid = 1'b0;
            s_axis.tdata  = 8'h00;
            s_axis.tlast  = 1'b0;
            s_axis.tuser  = 1'b0;
        end
        rmii_clk_en = slow ? (phase == 0) : 1'b1;
        phase = (phase == 9) ? 0 : phase + 1;
        @(negedge clk);
        strobe = rmii_clk_en;
        hs     = s_axis.tvalid && s_axis.tready;
        @(posedge clk);
        #1;
        if (strobe) cap_q.push_back({rmii_en, rmii_er, rmii_d});
        else if ({rmii_en, rmii_er, rmii_d} !== prev_pins) n_hold_viol++;
        prev_pins = {rmii_en, rmii_er, rmii_d};
        if (underrun) begin
            n_underrun++;
            stall_at = -1;
        end
        if (hs) begin
            void'(src_q.pop_front());
            n_acc++;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while ((src_q.size() > 0 || busy) && i < budget) begin
            run_cycle();
            i++;
        end
        repeat (4) run_cycle();
        check({tag, "_in_budget"}, 32'(i < budget), 32'd1);
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic er);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, er, b[2*k +: 2]});
    endtask

    // Reference: the whole frame as a list of {en,er,d} per dibit; ur_at<0 means no underrun.
    task automatic queue_frame(input int ur_at);
        beat_t b;
`ifdef RMII_TX_FCS_EN
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
`endif
        for (int i = 0; i < PRE_BYTES; i++) exp_byte(8'h55, 1'b0);
        exp_byte(8'hD5, 1'b0);
        for (int i = 0; i < f_dat.size(); i++) begin
            b.data = f_dat[i];
            b.last = (i == f_dat.size() - 1);
            b.user = f_usr[i];
            src_q.push_back(b);
            if (ur_at < 0 || i < ur_at) exp_byte(f_dat[i], f_usr[i]);
`ifdef RMII_TX_FCS_EN
            crc = crc_byte(crc, f_dat[i]);
`endif
        end
        if (ur_at >= 0) begin
            exp_q.push_back(4'b1100);
        end else begin
`ifdef RMII_TX_FCS_EN
            for (int j = 0; j < 4; j++) exp_byte(8'(~crc >> (8 * j)), 1'b0);
`endif
            for (int j = 0; j < 4 * IFG_BYTES; j++) exp_q.push_back(4'b0000);
        end
    endtask

    task automatic make_frame(input int len, input bit random_data);
        f_dat.delete();
        f_usr.delete();
        for (int i = 0; i < len; i++) begin
            f_dat.push_back(random_data ? 8'($urandom) : 8'(i));
            f_usr.push_back(random_data ? ($urandom_range(0, 7) == 0) : 1'b0);
        end
    endtask

    task automatic clear_capture();
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_capture(input string tag);
        int s;
        int tail_en;
        s = 0;
        while (s < cap_q.size() && cap_q[s][3] == 1'b0) s++;
        cap_start = s;
        check({tag, "_len"}, 32'(cap_q.size() - s >= exp_q.size()), 32'd1);
        if (cap_q.size() - s < exp_q.size()) return;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_dibit%0d", tag, i), 32'(cap_q[s + i]), 32'(exp_q[i]));
            if (cap_q[s + i] !== exp_q[i]) break;
        end
        tail_en = 0;
        for (int i = s + exp_q.size(); i < cap_q.size(); i++) if (cap_q[i][3]) tail_en++;
        check({tag, "_tail_en"}, 32'(tail_en), 32'd0);
    endtask

    initial begin
`ifdef RMII_TX_FCS_EN
        logic [31:0] res;
        logic [7:0]  rb;
`endif
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 8'hA5;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        rmii_clk_en   = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d", 32'(rmii_d), 32'd0);
        check("rst_en", 32'(rmii_en), 32'd0);
        check("rst_er", 32'(rmii_er), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_tready", 32'(s_axis.tready), 32'd0);
        s_axis.tvalid = 1'b0;
        rst_n = 1'b1;
        repeat (3) run_cycle();

        // 100M, 60-byte counting frame.
        make_frame(60, 1'b0);
        clear_capture();
        queue_frame(-1);
        wait_done("t1", 5000);
        compare_capture("t1_100m");
`ifdef RMII_TX_FCS_EN
        res = 32'hFFFFFFFF;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) rb[2*k +: 2] = cap_q[cap_start + 4*(PRE_BYTES + 1) + 4*i + k][1:0];
            res = crc_byte(res, rb);
        end
        check("t3_crc_residue", res, 32'hDEBB20E3);
`endif

        // 10M: same frame, pins only move on strobes.
        slow = 1'b1;
        phase = 0;
        n_hold_viol = 0;
        clear_capture();
        queue_frame(-1);
        wait_done("t2", 20000);
        compare_capture("t2_10m");
        check("t2_hold_between_strobes", 32'(n_hold_viol), 32'd0);
        slow = 1'b0;
        check("no_spurious_underrun", 32'(n_underrun), 32'd0);

        // Underrun: tvalid withheld before byte 10.
        n_underrun = 0;
        n_acc = 0;
        stall_at = 10;
        clear_capture();
        queue_frame(10);
        wait_done("t4", 5000);
        compare_capture("t4_underrun");
        check("t4_underrun_pulses", 32'(n_underrun), 32'd1);
        check("t4_drained", 32'(src_q.size()), 32'd0);
        check("t4_busy_after", 32'(busy), 32'd0);
        stall_at = -1;
        n_underrun = 0;

        // tuser on byte 5 only.
        make_frame(60, 1'b0);
        f_usr[5] = 1'b1;
        clear_capture();
        queue_frame(-1);
        wait_done("t5", 5000);
        compare_capture("t5_tuser");

        // Random back-to-back pairs, random rate; the first frame is the 1-byte minimum.
        for (int r = 0; r < 4; r++) begin
            slow = ($urandom_range(0, 2) == 0);
            phase = 0;
            clear_capture();
            for (int f = 0; f < 2; f++) begin
                make_frame((r == 0 && f == 0) ? 1 : int'($urandom_range(1, 24)), 1'b1);
                queue_frame(-1);
            end
            wait_done($sformatf("rand%0d", r), 30000);
            compare_capture($sformatf("rand%0d", r));
        end
        slow = 1'b0;
        check("rand_no_underrun", 32'(n_underrun), 32'd0);

        // Reset in the middle of DATA, then a fresh frame.
        make_frame(30, 1'b1);
        clear_capture();
        queue_frame(-1);
        repeat (32 + 20) run_cycle();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", 32'(rmii_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        src_q.delete();
        repeat (2) run_cycle();
        rst_n = 1'b1;
        make_frame(8, 1'b1);
        clear_capture();
        queue_frame(-1);
        wait_done("t7", 5000);
        compare_capture("t7_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
